// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_sequencer
//  Description : Programmable LED pattern sequencer. An 8-entry step table
//                holds {dur, mask} pairs. A prescaler produces a tick every
//                DIVISOR clocks, and a two-state controller walks the table
//                in one-shot or loop mode under start/stop control.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer #(
    parameter logic [31:0] DIVISOR   = 32'd12000000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [8:0] wr_data,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic [4:0] led,
    output logic       busy,
    output logic [2:0] step_idx,
    output logic       done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Terminal prescaler count; tick is asserted while the count sits here.
    localparam logic [CNT_WIDTH-1:0] c_tick_max = CNT_WIDTH'(DIVISOR - 32'd1);
    localparam logic [CNT_WIDTH-1:0] c_one      = CNT_WIDTH'(1);

    // Step table: bits [8:5] hold the duration in ticks, bits [4:0] the mask.
    logic [8:0]           table_q [8];

    state_t               state_q,     state_d;
    logic [4:0]           led_q,       led_d;
    logic [2:0]           step_idx_q,  step_idx_d;
    logic [3:0]           remaining_q, remaining_d;
    logic [CNT_WIDTH-1:0] presc_q,     presc_d;
    logic                 done_q,      done_d;

    logic                 w_tick;
    logic [2:0]           w_nxt;
    logic                 w_end_pat;
    logic [3:0]           w_dur0;
    logic [4:0]           w_mask0;
    logic [3:0]           w_dur_nxt;
    logic [4:0]           w_mask_nxt;

    assign w_tick     = (presc_q == c_tick_max);
    assign w_nxt      = step_idx_q + 3'd1;
    assign w_dur0     = table_q[0][8:5];
    assign w_mask0    = table_q[0][4:0];
    assign w_dur_nxt  = table_q[w_nxt][8:5];
    assign w_mask_nxt = table_q[w_nxt][4:0];
    // Step 7 is always last; otherwise a zero duration terminates the pattern.
    assign w_end_pat  = (step_idx_q == 3'd7) || (w_dur_nxt == 4'd0);

    // Step table storage; writes are accepted in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                table_q[i] <= 9'd0;
            end
        end else if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    // Controller state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            led_q       <= 5'd0;
            step_idx_q  <= 3'd0;
            remaining_q <= 4'd0;
            presc_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            step_idx_q  <= step_idx_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: step entry latches mask/dur so later table writes
    // to the running entry only show up on its next entry.
    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        step_idx_d  = step_idx_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                led_d       = 5'd0;
                step_idx_d  = 3'd0;
                remaining_d = 4'd0;
                presc_d     = '0;
                if (start && !stop) begin
                    if (w_dur0 != 4'd0) begin
                        state_d     = S_RUN;
                        led_d       = w_mask0;
                        remaining_d = w_dur0;
                    end else begin
                        // Empty pattern: complete immediately.
                        done_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (stop) begin
                    state_d     = S_IDLE;
                    led_d       = 5'd0;
                    step_idx_d  = 3'd0;
                    remaining_d = 4'd0;
                    presc_d     = '0;
                end else begin
                    presc_d = w_tick ? '0 : (presc_q + c_one);
                    if (w_tick) begin
                        if (remaining_q > 4'd1) begin
                            remaining_d = remaining_q - 4'd1;
                        end else if (!w_end_pat) begin
                            step_idx_d  = w_nxt;
                            led_d       = w_mask_nxt;
                            remaining_d = w_dur_nxt;
                        end else if (loop) begin
                            // Prescaler keeps running so step periods stay exact.
                            step_idx_d  = 3'd0;
                            led_d       = w_mask0;
                            remaining_d = w_dur0;
                        end else begin
                            state_d     = S_IDLE;
                            led_d       = 5'd0;
                            step_idx_d  = 3'd0;
                            remaining_d = 4'd0;
                            presc_d     = '0;
                            done_d      = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign led      = led_q;
    assign busy     = (state_q == S_RUN);
    assign step_idx = step_idx_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_sequencer
//  Description : Directed self-checking bench for led_pattern_sequencer with
//                DIVISOR=4. Observed outputs are packed {led,busy,idx,done}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [8:0] wr_data = 9'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic [4:0] led;
    logic       busy;
    logic [2:0] step_idx;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic [9:0] obs;
    logic [9:0] exp_v;
    assign obs = {led, busy, step_idx, done};

    led_pattern_sequencer #(
        .DIVISOR   (32'd4),
        .CNT_WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .led      (led),
        .busy     (busy),
        .step_idx (step_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic [4:0] m);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = {d, m};
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++;
        if (obs !== 10'b00000_0_000_0) begin
            bad++;
            $display("FAIL reset got=%b want=%b", obs, 10'b00000_0_000_0);
        end
    endtask

    // Basic table: entry0={2,00001}, entry1={1,10101}, entry2.dur=0.
    task automatic load_basic();
        wr(3'd0, 4'd2, 5'b00001);
        wr(3'd1, 4'd1, 5'b10101);
        wr(3'd2, 4'd0, 5'b00000);
    endtask

    task automatic test_one_shot();
        load_basic();
        loop  = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            start = 1'b0;
            if (k <= 8)       exp_v = {5'b00001, 1'b1, 3'd0, 1'b0};
            else if (k <= 12) exp_v = {5'b10101, 1'b1, 3'd1, 1'b0};
            else if (k == 13) exp_v = {5'b00000, 1'b0, 3'd0, 1'b1};
            else              exp_v = {5'b00000, 1'b0, 3'd0, 1'b0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL one_shot k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_full_table();
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 4'd1, 5'(i + 1));
        end
        loop  = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            step();
            start = 1'b0;
            if (k <= 32)      exp_v = {5'((k - 1) / 4 + 1), 1'b1, 3'((k - 1) / 4), 1'b0};
            else if (k == 33) exp_v = {5'b00000, 1'b0, 3'd0, 1'b1};
            else              exp_v = {5'b00000, 1'b0, 3'd0, 1'b0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL full_table k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    // Loop for three passes; entry1 mask is rewritten mid-step1 of pass 1,
    // loop drops during pass 3 so done appears at its end.
    task automatic test_loop_live_write();
        load_basic();
        loop  = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            step();
            start = 1'b0;
            wr_en = 1'b0;
            if (k <= 8 || (k >= 13 && k <= 20) || (k >= 25 && k <= 32))
                exp_v = {5'b00001, 1'b1, 3'd0, 1'b0};
            else if (k <= 12)
                exp_v = {5'b10101, 1'b1, 3'd1, 1'b0};
            else if (k <= 24 || (k >= 33 && k <= 36))
                exp_v = {5'b11111, 1'b1, 3'd1, 1'b0};
            else if (k == 37)
                exp_v = {5'b00000, 1'b0, 3'd0, 1'b1};
            else
                exp_v = {5'b00000, 1'b0, 3'd0, 1'b0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL loop_live k=%0d got=%b want=%b", k, obs, exp_v);
            end
            if (k == 10) begin
                wr_en   = 1'b1;
                wr_addr = 3'd1;
                wr_data = {4'd1, 5'b11111};
            end
            if (k == 30) loop = 1'b0;
        end
    endtask

    task automatic test_stop();
        load_basic();
        loop  = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            start = 1'b0;
            stop  = 1'b0;
            if (k <= 6) exp_v = {5'b00001, 1'b1, 3'd0, 1'b0};
            else        exp_v = {5'b00000, 1'b0, 3'd0, 1'b0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL stop k=%0d got=%b want=%b", k, obs, exp_v);
            end
            if (k == 6) stop = 1'b1;
        end
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            total++;
            if (obs !== 10'b00000_0_000_0) begin
                bad++;
                $display("FAIL start_stop_idle k=%0d got=%b want=%b", k, obs, 10'b00000_0_000_0);
            end
            step();
        end
    endtask

    task automatic test_start_during_run();
        loop  = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            start = 1'b0;
            if (k <= 8)       exp_v = {5'b00001, 1'b1, 3'd0, 1'b0};
            else if (k <= 12) exp_v = {5'b10101, 1'b1, 3'd1, 1'b0};
            else              exp_v = {5'b00000, 1'b0, 3'd0, 1'b1};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL start_in_run k=%0d got=%b want=%b", k, obs, exp_v);
            end
            if (k == 5 || k == 9) start = 1'b1;
        end
        step();
    endtask

    task automatic test_empty_pattern();
        wr(3'd0, 4'd0, 5'b11111);
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (obs !== 10'b00000_0_000_1) begin
            bad++;
            $display("FAIL empty_done got=%b want=%b", obs, 10'b00000_0_000_1);
        end
        step();
        total++;
        if (obs !== 10'b00000_0_000_0) begin
            bad++;
            $display("FAIL empty_after got=%b want=%b", obs, 10'b00000_0_000_0);
        end
    endtask

    task automatic test_reset_mid_run();
        load_basic();
        start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            start = 1'b0;
        end
        total++;
        if (obs !== 10'b00001_1_000_0) begin
            bad++;
            $display("FAIL pre_reset got=%b want=%b", obs, 10'b00001_1_000_0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (obs !== 10'b00000_0_000_0) begin
            bad++;
            $display("FAIL mid_reset got=%b want=%b", obs, 10'b00000_0_000_0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (obs !== 10'b00000_0_000_1) begin
            bad++;
            $display("FAIL post_reset_empty got=%b want=%b", obs, 10'b00000_0_000_1);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_full_table();
        test_loop_live_write();
        test_stop();
        test_start_stop_idle();
        test_start_during_run();
        test_empty_pattern();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
